stereo_effect_scheduler: RTL

Time-shares one mono effect instance, such as the clipping effect, between the left and right channels of a stereo sample stream. The block sits between the audio source (I2S receiver) and sink (I2S transmitter). It latches each stereo frame and sequences the left sample, then the right sample, through the effect's ready/enable/valid/done handshake. It then emits the processed frame and supports per-channel bypass and an effect-hang timeout.

---
 rtl/stereo_effect_scheduler_if.sv | 19 +
 rtl/stereo_effect_scheduler.sv | 80 ++++++++
 2 files changed

// File: rtl/stereo_effect_scheduler_if.sv
// stereo_effect_scheduler_if: stereo frame, bypass and mono-effect handshake signals
interface stereo_effect_scheduler_if #(parameter int data_width = 16);
  logic [data_width-1:0] i_left, i_right, o_left, o_right, o_fx_data, i_fx_data;
  logic i_sample_valid, o_sample_ready, o_sample_valid, i_bypass_left, i_bypass_right;
  logic o_fx_data_ready, i_fx_read_enable, i_fx_data_valid, o_fx_read_done;
  logic o_busy, o_timeout_err, o_overrun_err;
  modport slave (
    input  i_left, i_right, i_sample_valid, i_bypass_left, i_bypass_right,
           i_fx_read_enable, i_fx_data, i_fx_data_valid,
    output o_left, o_right, o_sample_ready, o_sample_valid, o_fx_data, o_fx_data_ready,
           o_fx_read_done, o_busy, o_timeout_err, o_overrun_err
  );
  modport master (
    output i_left, i_right, i_sample_valid, i_bypass_left, i_bypass_right,
           i_fx_read_enable, i_fx_data, i_fx_data_valid,
    input  o_left, o_right, o_sample_ready, o_sample_valid, o_fx_data, o_fx_data_ready,
           o_fx_read_done, o_busy, o_timeout_err, o_overrun_err
  );
endinterface

// File: rtl/stereo_effect_scheduler.sv
// stereo_effect_scheduler: time-shares one mono effect between the left and right channels of a stereo stream
module stereo_effect_scheduler #(
  parameter int data_width = 16,
  parameter int timeout_cycles = 255
) (
  input logic clk,
  input logic reset,
  stereo_effect_scheduler_if.slave bus
);
  localparam int cw = $clog2(timeout_cycles + 1);
  localparam logic [cw-1:0] limit = cw'(timeout_cycles - 1);
  typedef enum logic [2:0] {IDLE, SEND_L, WAIT_L, SEND_R, WAIT_R, EMIT} state_t;
  state_t state, next;
  logic [cw-1:0] cnt;
  logic [data_width-1:0] res_l, res_r;
  logic byp_r, fresh, accept, in_send, in_wait, issue, got, expired, finish;
  always_comb begin
    accept = bus.i_sample_valid && state == IDLE;
    in_send = state == SEND_L || state == SEND_R;
    in_wait = state == WAIT_L || state == WAIT_R;
    issue = in_send && bus.i_fx_read_enable;
    got = in_wait && !fresh && bus.i_fx_data_valid;
    expired = (in_send || in_wait) && !issue && !got && cnt >= limit;
    finish = got || expired;
    next = state;
    case (state)
      IDLE:    next = !accept ? IDLE : !bus.i_bypass_left ? SEND_L : !bus.i_bypass_right ? SEND_R : EMIT;
      SEND_L:  next = issue ? WAIT_L : expired ? (byp_r ? EMIT : SEND_R) : SEND_L;
      WAIT_L:  next = finish ? (byp_r ? EMIT : SEND_R) : WAIT_L;
      SEND_R:  next = issue ? WAIT_R : expired ? EMIT : SEND_R;
      WAIT_R:  next = finish ? EMIT : WAIT_R;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  // result registers start as the raw inputs, so bypass and timeout fall out as pass-through
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      fresh <= 1'b0;
      byp_r <= 1'b0;
      res_l <= '0;
      res_r <= '0;
      bus.o_left <= '0;
      bus.o_right <= '0;
      bus.o_fx_data <= '0;
      bus.o_sample_ready <= 1'b1;
      bus.o_sample_valid <= 1'b0;
      bus.o_fx_data_ready <= 1'b0;
      bus.o_fx_read_done <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_timeout_err <= 1'b0;
      bus.o_overrun_err <= 1'b0;
    end else begin
      cnt <= (next != state && (next == SEND_L || next == SEND_R)) ? '0 : cnt + 1'b1;
      fresh <= issue;
      bus.o_sample_ready <= next == IDLE;
      bus.o_busy <= next != IDLE;
      bus.o_fx_data_ready <= issue;
      bus.o_fx_read_done <= finish;
      bus.o_sample_valid <= state == EMIT;
      if (accept) begin
        res_l <= bus.i_left;
        res_r <= bus.i_right;
        byp_r <= bus.i_bypass_right;
      end
      if (issue) bus.o_fx_data <= state == SEND_L ? res_l : res_r;
      if (got && state == WAIT_L) res_l <= bus.i_fx_data;
      if (got && state == WAIT_R) res_r <= bus.i_fx_data;
      if (state == EMIT) begin
        bus.o_left <= res_l;
        bus.o_right <= res_r;
      end
      if (expired) bus.o_timeout_err <= 1'b1;
      if (bus.i_sample_valid && !bus.o_sample_ready) bus.o_overrun_err <= 1'b1;
    end
  end
endmodule
